countdown_timer_bcd: RTL and testbench

Microwave cook-time countdown. Holds a BCD MM:SS value, loaded from the keypad/setup path, and decrements it once per 1 Hz tick while running. The decrement uses a borrow chain: seconds-ones mod 10, seconds-tens mod 6, minutes-ones mod 10, minutes-tens mod 10. This is the down-counting counterpart of the existing mod-10 up counter. Outputs drive the 7-seg display decoders and the magnetron/lamp control FSM.

---
 rtl/countdown_timer_bcd.sv | 147 ++++++++++++++
 tb/tb_countdown_timer_bcd.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_bcd.sv
// BCD MM:SS cook-time countdown with load clamping, pause/resume and a done pulse.
// Optional completion beeper is compiled in with `define DONE_BEEP_EN.
module countdown_timer_bcd #(
  parameter int MAX_MIN_TENS = 9,
  parameter int BEEP_TICKS   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] d_min_t,
  input  logic [3:0] d_min_o,
  input  logic [3:0] d_sec_t,
  input  logic [3:0] d_sec_o,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic       running,
  output logic       done,
  output logic       beep
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  localparam logic [3:0] MT_MAX = (MAX_MIN_TENS > 9) ? 4'd9 : 4'(MAX_MIN_TENS);

  state_t     state_q, state_d;
  logic [3:0] mt_q, mo_q, st_q, so_q;
  logic [3:0] mt_d, mo_d, st_d, so_d;
  logic       running_q, done_q, done_d;

  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
  logic       b0, b1, b2;
  logic       time_zero, time_one, load_ok;

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  assign time_zero = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);
  assign time_one  = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd1);
  assign load_ok   = load && (state_q != RUN);

  // Borrow chain: each digit wraps only when every lower digit is wrapping.
  always_comb begin
    b0     = (so_q == 4'd0);
    dec_so = b0 ? 4'd9 : so_q - 4'd1;
    b1     = b0 && (st_q == 4'd0);
    dec_st = b0 ? ((st_q == 4'd0) ? 4'd5 : st_q - 4'd1) : st_q;
    b2     = b1 && (mo_q == 4'd0);
    dec_mo = b1 ? ((mo_q == 4'd0) ? 4'd9 : mo_q - 4'd1) : mo_q;
    dec_mt = b2 ? mt_q - 4'd1 : mt_q;
  end

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mo_d    = mo_q;
    st_d    = st_q;
    so_d    = so_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      mt_d    = 4'd0;
      mo_d    = 4'd0;
      st_d    = 4'd0;
      so_d    = 4'd0;
    end else if (load_ok) begin
      state_d = IDLE;
      mt_d    = clamp(d_min_t, MT_MAX);
      mo_d    = clamp(d_min_o, 4'd9);
      st_d    = clamp(d_sec_t, 4'd5);
      so_d    = clamp(d_sec_o, 4'd9);
    end else if (pause && (state_q == RUN)) begin
      state_d = PAUSED;
    end else if (start && ((state_q == IDLE) || (state_q == PAUSED)) && !time_zero) begin
      state_d = RUN;
    end else if (tick && (state_q == RUN)) begin
      mt_d = dec_mt;
      mo_d = dec_mo;
      st_d = dec_st;
      so_d = dec_so;
      if (time_one) begin
        state_d = DONE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mt_q      <= 4'd0;
      mo_q      <= 4'd0;
      st_q      <= 4'd0;
      so_q      <= 4'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mt_q      <= mt_d;
      mo_q      <= mo_d;
      st_q      <= st_d;
      so_q      <= so_d;
      running_q <= (state_d == RUN);
      done_q    <= done_d;
    end
  end

`ifdef DONE_BEEP_EN
  localparam int BW = (BEEP_TICKS < 1) ? 1 : $clog2(BEEP_TICKS + 1);

  logic [BW-1:0] beep_cnt_q, beep_cnt_d;

  // Counts remaining ticks of beeping; only ticks seen while already in DONE count down.
  always_comb begin
    beep_cnt_d = beep_cnt_q;
    if (clear || load_ok)
      beep_cnt_d = '0;
    else if (done_d)
      beep_cnt_d = BW'(BEEP_TICKS);
    else if ((state_q == DONE) && tick && (beep_cnt_q != '0))
      beep_cnt_d = beep_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) beep_cnt_q <= '0;
    else        beep_cnt_q <= beep_cnt_d;
  end

  assign beep = (beep_cnt_q != '0);
`else
  assign beep = 1'b0;
`endif

  assign min_t   = mt_q;
  assign min_o   = mo_q;
  assign sec_t   = st_q;
  assign sec_o   = so_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Bench for countdown_timer_bcd: directed vector table, corner sequences,
// and random stimulus against a seconds-count reference model.
module tb_countdown_timer_bcd;

  localparam int MAXMT = 9;
  localparam int BT    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, tick, load, start, pause, clear;
  logic [3:0] d_min_t, d_min_o, d_sec_t, d_sec_o;
  logic [3:0] min_t, min_o, sec_t, sec_o;
  logic       running, done, beep;

  countdown_timer_bcd #(.MAX_MIN_TENS(MAXMT), .BEEP_TICKS(BT)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(load),
    .d_min_t(d_min_t), .d_min_o(d_min_o), .d_sec_t(d_sec_t), .d_sec_o(d_sec_o),
    .start(start), .pause(pause), .clear(clear),
    .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o),
    .running(running), .done(done), .beep(beep)
  );

  typedef struct {
    logic        r, c, l, p, s, t;
    logic [15:0] d;
    logic [15:0] et;
    logic        er, ed;
  } vec_t;

  vec_t vq[$];
  int total = 0;
  int bad   = 0;

  // Reference model: time as a plain seconds count.
  int m_mode;   // 0 idle, 1 run, 2 paused, 3 done
  int m_secs;
  int m_beep;
  logic m_done;

  function automatic logic [15:0] disp();
    return {min_t, min_o, sec_t, sec_o};
  endfunction

  function automatic int mn(input int a, input int b);
    return (a > b) ? b : a;
  endfunction

  function automatic int ld_secs(input logic [15:0] d);
    return mn(int'(d[15:12]), MAXMT) * 600 + mn(int'(d[11:8]), 9) * 60 +
           mn(int'(d[7:4]), 5) * 10 + mn(int'(d[3:0]), 9);
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, c, l, p, s, t, input logic [15:0] d, et,
                     input logic er, ed);
    vec_t v;
    v.r = r; v.c = c; v.l = l; v.p = p; v.s = s; v.t = t;
    v.d = d; v.et = et; v.er = er; v.ed = ed;
    vq.push_back(v);
  endtask

  task automatic drv(input logic r, c, l, p, s, t, input logic [15:0] d);
    @(negedge clk);
    rst_n = r; clear = c; load = l; pause = p; start = s; tick = t;
    {d_min_t, d_min_o, d_sec_t, d_sec_o} = d;
  endtask

  task automatic cyc(input logic r, c, l, p, s, t, input logic [15:0] d);
    drv(r, c, l, p, s, t, d);
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input logic r, c, l, p, s, t, input logic [15:0] d);
    m_done = 1'b0;
    if (!r) begin
      m_mode = 0; m_secs = 0; m_beep = 0;
    end else if (c) begin
      m_mode = 0; m_secs = 0; m_beep = 0;
    end else if (l && m_mode != 1) begin
      m_mode = 0; m_secs = ld_secs(d); m_beep = 0;
    end else if (p && m_mode == 1) begin
      m_mode = 2;
    end else if (s && (m_mode == 0 || m_mode == 2) && m_secs != 0) begin
      m_mode = 1;
    end else if (t && m_mode == 1) begin
      m_secs--;
      if (m_secs == 0) begin
        m_mode = 3; m_done = 1'b1; m_beep = BT;
      end
    end else if (t && m_mode == 3 && m_beep > 0) begin
      m_beep--;
    end
  endtask

  logic exp_beep;

  initial begin
    rst_n = 0; clear = 0; load = 0; pause = 0; start = 0; tick = 0;
    {d_min_t, d_min_o, d_sec_t, d_sec_o} = '0;

    //   r  c  l  p  s  t  d         exp       run done
    add(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    add(1, 0, 1, 0, 0, 0, 16'h0105, 16'h0105, 0, 0);
    add(1, 0, 0, 0, 1, 0, 16'h0000, 16'h0105, 1, 0);
    add(1, 0, 0, 0, 0, 1, 16'h0000, 16'h0104, 1, 0);
    add(1, 0, 0, 0, 0, 1, 16'h0000, 16'h0103, 1, 0);
    add(1, 0, 0, 0, 0, 1, 16'h0000, 16'h0102, 1, 0);
    add(1, 0, 0, 0, 0, 1, 16'h0000, 16'h0101, 1, 0);
    add(1, 0, 0, 0, 0, 1, 16'h0000, 16'h0100, 1, 0);
    add(1, 0, 0, 0, 0, 1, 16'h0000, 16'h0059, 1, 0);
    add(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    add(1, 0, 1, 0, 0, 0, 16'h0002, 16'h0002, 0, 0);
    add(1, 0, 0, 0, 1, 1, 16'h0000, 16'h0002, 1, 0);
    add(1, 0, 0, 0, 0, 1, 16'h0000, 16'h0001, 1, 0);
    add(1, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1);
    add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    add(1, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0);
    add(1, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0);
    add(1, 0, 1, 0, 0, 0, 16'hCF79, 16'h9959, 0, 0);
    add(1, 0, 0, 0, 1, 0, 16'h0000, 16'h9959, 1, 0);
    add(1, 0, 0, 0, 0, 1, 16'h0000, 16'h9958, 1, 0);
    add(1, 0, 1, 0, 0, 0, 16'h0100, 16'h9958, 1, 0);
    add(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    add(1, 0, 1, 0, 0, 0, 16'h1000, 16'h1000, 0, 0);
    add(1, 0, 0, 0, 0, 1, 16'h0000, 16'h1000, 0, 0);
    add(1, 0, 0, 0, 1, 0, 16'h0000, 16'h1000, 1, 0);
    add(1, 0, 0, 0, 0, 1, 16'h0000, 16'h0959, 1, 0);
    add(1, 0, 0, 1, 0, 0, 16'h0000, 16'h0959, 0, 0);
    add(1, 0, 0, 0, 1, 0, 16'h0000, 16'h0959, 1, 0);
    add(1, 0, 0, 0, 0, 1, 16'h0000, 16'h0958, 1, 0);

    foreach (vq[i]) begin
      cyc(vq[i].r, vq[i].c, vq[i].l, vq[i].p, vq[i].s, vq[i].t, vq[i].d);
      chk($sformatf("vec%0d_time", i), 32'(disp()), 32'(vq[i].et));
      chk($sformatf("vec%0d_run", i), 32'(running), 32'(vq[i].er));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vq[i].ed));
`ifndef DONE_BEEP_EN
      chk($sformatf("vec%0d_beep", i), 32'(beep), 32'd0);
`endif
    end

    // Pause with a same-cycle tick drops the tick; ticks while paused are ignored.
    cyc(1, 1, 0, 0, 0, 0, 16'h0000);
    cyc(1, 0, 1, 0, 0, 0, 16'h0030);
    cyc(1, 0, 0, 0, 1, 0, 16'h0000);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 1, 16'h0000);
    chk("pz_pre", 32'(disp()), 32'h0027);
    cyc(1, 0, 0, 1, 0, 1, 16'h0000);
    chk("pz_hold", 32'(disp()), 32'h0027);
    chk("pz_run", 32'(running), 32'd0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 1, 16'h0000);
    chk("pz_still", 32'(disp()), 32'h0027);
    cyc(1, 0, 0, 0, 1, 0, 16'h0000);
    chk("pz_resume", 32'(running), 32'd1);
    cyc(1, 0, 0, 0, 0, 1, 16'h0000);
    chk("pz_after", 32'(disp()), 32'h0026);

    // Clear from RUN.
    cyc(1, 1, 0, 0, 0, 0, 16'h0000);
    cyc(1, 0, 1, 0, 0, 0, 16'h0500);
    cyc(1, 0, 0, 0, 1, 0, 16'h0000);
    cyc(1, 1, 0, 0, 0, 1, 16'h0000);
    chk("clr_time", 32'(disp()), 32'h0000);
    chk("clr_run", 32'(running), 32'd0);
    chk("clr_done", 32'(done), 32'd0);

    // Reset mid-RUN.
    cyc(1, 0, 1, 0, 0, 0, 16'h0500);
    cyc(1, 0, 0, 0, 1, 0, 16'h0000);
    cyc(1, 0, 0, 0, 0, 1, 16'h0000);
    chk("rst_pre", 32'(disp()), 32'h0459);
    cyc(0, 0, 0, 0, 1, 1, 16'h0000);
    chk("rst_time", 32'(disp()), 32'h0000);
    chk("rst_outs", 32'({running, done, beep}), 32'd0);

`ifdef DONE_BEEP_EN
    cyc(1, 0, 1, 0, 0, 0, 16'h0001);
    cyc(1, 0, 0, 0, 1, 0, 16'h0000);
    cyc(1, 0, 0, 0, 0, 1, 16'h0000);
    chk("bp_enter", 32'({done, beep}), 32'h3);
    for (int i = 0; i < BT; i++) begin
      cyc(1, 0, 0, 0, 0, 1, 16'h0000);
      chk($sformatf("bp_tick%0d", i), 32'(beep), (i < BT - 1) ? 32'd1 : 32'd0);
    end
    cyc(1, 0, 1, 0, 0, 0, 16'h0001);
    cyc(1, 0, 0, 0, 1, 0, 16'h0000);
    cyc(1, 0, 0, 0, 0, 1, 16'h0000);
    cyc(1, 1, 0, 0, 0, 0, 16'h0000);
    chk("bp_clear", 32'(beep), 32'd0);
`endif

    // Random stimulus against the seconds-count model.
    cyc(0, 0, 0, 0, 0, 0, 16'h0000);
    model_step(0, 0, 0, 0, 0, 0, 16'h0000);
    for (int n = 0; n < 3000; n++) begin
      logic r, c, l, p, s, t;
      logic [15:0] d;
      r = ($urandom_range(0, 299) != 0);
      c = ($urandom_range(0, 59) == 0);
      l = ($urandom_range(0, 19) == 0);
      p = ($urandom_range(0, 11) == 0);
      s = ($urandom_range(0, 5) == 0);
      t = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) != 0) d = {12'h000, 4'($urandom_range(0, 3))};
      else                           d = 16'($urandom);
      cyc(r, c, l, p, s, t, d);
      model_step(r, c, l, p, s, t, d);
`ifdef DONE_BEEP_EN
      exp_beep = (m_beep > 0);
`else
      exp_beep = 1'b0;
`endif
      chk("rnd_time", 32'(disp()), 32'(to_bcd(m_secs)));
      chk("rnd_flags", 32'({running, done, beep}),
          32'({(m_mode == 1), m_done, exp_beep}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
